// File: rtl/td4_board_top.sv
// Board top for a 4-bit TD4-class CPU with a fixed program ROM.
// A prescaler paces execution so the CPU's progress is visible on the LEDs.
module td4_board_top #(
    parameter int RATIO = 12_000_000
) (
    input  logic       pin_clock,
    input  logic       pin_reset,
    input  logic [3:0] pin_switch,
    output logic [3:0] pin_led
);

    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    logic [CW-1:0] counter;
    logic          step;

    logic [3:0] sw_meta;
    logic [3:0] sw_sync;

    logic [3:0] pc;
    logic [3:0] reg_a;
    logic [3:0] reg_b;
    logic [3:0] reg_out;
    logic       carry;

    logic [7:0] instr;
    logic [3:0] op;
    logic [3:0] im;
    logic [4:0] sum_a;
    logic [4:0] sum_b;

    logic [3:0] pc_next;
    logic [3:0] a_next;
    logic [3:0] b_next;
    logic [3:0] out_next;
    logic       carry_next;

    always_ff @(posedge pin_clock) begin
        if (pin_reset) begin
            counter <= '0;
        end else if (counter == LAST) begin
            counter <= '0;
        end else begin
            counter <= counter + CW'(1);
        end
    end

    // Gated by reset so no step is seen while the board is held in reset.
    assign step = (counter == LAST) && !pin_reset;

    // Synchronizer runs freely, so the switches are settled by reset release.
    always_ff @(posedge pin_clock) begin
        sw_meta <= pin_switch;
        sw_sync <= sw_meta;
    end

    always_comb begin
        instr = 8'h00;
        case (pc)
            4'h0:    instr = 8'h20;
            4'h1:    instr = 8'h40;
            4'h2:    instr = 8'h90;
            4'h3:    instr = 8'h01;
            4'h4:    instr = 8'h40;
            4'h5:    instr = 8'h90;
            4'h6:    instr = 8'hF3;
            default: instr = 8'h00;
        endcase
    end

    assign op    = instr[7:4];
    assign im    = instr[3:0];
    assign sum_a = {1'b0, reg_a} + {1'b0, im};
    assign sum_b = {1'b0, reg_b} + {1'b0, im};

    always_comb begin
        pc_next    = pc + 4'd1;
        a_next     = reg_a;
        b_next     = reg_b;
        out_next   = reg_out;
        carry_next = 1'b0;
        case (op)
            4'b0000: {carry_next, a_next} = sum_a;
            4'b0001: a_next = reg_b;
            4'b0010: a_next = sw_sync;
            4'b0011: a_next = im;
            4'b0100: b_next = reg_a;
            4'b0101: {carry_next, b_next} = sum_b;
            4'b0110: b_next = sw_sync;
            4'b0111: b_next = im;
            4'b1001: out_next = reg_b;
            4'b1011: out_next = im;
            4'b1110: begin
                if (!carry) begin
                    pc_next = im;
                end
            end
            4'b1111: pc_next = im;
            default: ;
        endcase
    end

    always_ff @(posedge pin_clock) begin
        if (pin_reset) begin
            pc      <= '0;
            reg_a   <= '0;
            reg_b   <= '0;
            reg_out <= '0;
            carry   <= 1'b0;
        end else if (step) begin
            pc      <= pc_next;
            reg_a   <= a_next;
            reg_b   <= b_next;
            reg_out <= out_next;
            carry   <= carry_next;
        end
    end

    assign pin_led = reg_out;

endmodule

// File: tb/tb_td4_board_top.sv
// Directed bench for td4_board_top at RATIO=2: reset, prescaler, program
// sequence, 4-bit wrap with carry, and a mid-run reset.
module tb_td4_board_top;

    logic       pin_clock;
    logic       pin_reset;
    logic [3:0] pin_switch;
    logic [3:0] pin_led;

    int n_checks;
    int n_pass;
    int edge_n;
    logic [7:0] exp_q[$];

    td4_board_top #(.RATIO(2)) dut (
        .pin_clock  (pin_clock),
        .pin_reset  (pin_reset),
        .pin_switch (pin_switch),
        .pin_led    (pin_led)
    );

    initial pin_clock = 1'b0;
    always #5 pin_clock = ~pin_clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp_v, edge_n);
        end
    endtask

    task automatic tick();
        @(posedge pin_clock);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int target);
        while (edge_n < target) tick();
    endtask

    task automatic check_led_q(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: expected queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, {4'd0, pin_led}, e);
        end
    endtask

    task automatic do_reset(input int cycles);
        pin_reset = 1'b1;
        repeat (cycles) tick();
        pin_reset = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        edge_n   = 0;
        pin_reset  = 1'b1;
        pin_switch = 4'd6;

        // Reset state
        do_reset(3);
        pin_reset = 1'b1;
        check("rst_led", {4'd0, pin_led}, 8'd0);
        check("rst_pc", {4'd0, dut.pc}, 8'd0);
        check("rst_step", {7'd0, dut.step}, 8'd0);
        pin_reset = 1'b0;

        exp_q.push_back(8'd6);
        exp_q.push_back(8'd7);
        exp_q.push_back(8'd8);
        exp_q.push_back(8'd9);

        // Prescaler and load
        run_to(1);
        check("e1_step", {7'd0, dut.step}, 8'd1);
        check("e1_a", {4'd0, dut.reg_a}, 8'd0);
        check("e1_pc", {4'd0, dut.pc}, 8'd0);
        run_to(2);
        check("e2_step", {7'd0, dut.step}, 8'd0);
        check("e2_a", {4'd0, dut.reg_a}, 8'd6);
        check("e2_pc", {4'd0, dut.pc}, 8'd1);
        run_to(6);
        check_led_q("e6_led");
        check("e6_pc", {4'd0, dut.pc}, 8'd3);
        run_to(8);
        check("e8_a", {4'd0, dut.reg_a}, 8'd7);
        run_to(12);
        check_led_q("e12_led");

        // Count loop and jump
        run_to(14);
        check("e14_pc", {4'd0, dut.pc}, 8'd3);
        run_to(16);
        check("e16_pc", {4'd0, dut.pc}, 8'd4);
        run_to(18);
        check("e18_pc", {4'd0, dut.pc}, 8'd5);
        run_to(20);
        check_led_q("e20_led");
        check("e20_pc", {4'd0, dut.pc}, 8'd6);
        run_to(22);
        check("e22_pc", {4'd0, dut.pc}, 8'd3);
        run_to(28);
        check_led_q("e28_led");
        run_to(49);
        check("e49_led", {4'd0, pin_led}, 8'd11);

        // Mid-run reset at edge 50
        pin_reset = 1'b1;
        run_to(50);
        pin_reset = 1'b0;
        check("mid_led", {4'd0, pin_led}, 8'd0);
        check("mid_pc", {4'd0, dut.pc}, 8'd0);
        check("mid_a", {4'd0, dut.reg_a}, 8'd0);
        edge_n = 0;
        run_to(2);
        check("mid_e2_a", {4'd0, dut.reg_a}, 8'd6);
        check("mid_e2_pc", {4'd0, dut.pc}, 8'd1);
        run_to(6);
        check("mid_e6_led", {4'd0, pin_led}, 8'd6);

        // Wrap with carry
        pin_switch = 4'd15;
        do_reset(3);
        run_to(6);
        check("wr_e6_led", {4'd0, pin_led}, 8'd15);
        run_to(8);
        check("wr_e8_a", {4'd0, dut.reg_a}, 8'd0);
        check("wr_e8_carry", {7'd0, dut.carry}, 8'd1);
        check("wr_e8_pc", {4'd0, dut.pc}, 8'd4);
        run_to(10);
        check("wr_e10_carry", {7'd0, dut.carry}, 8'd0);
        check("wr_e10_b", {4'd0, dut.reg_b}, 8'd0);
        run_to(12);
        check("wr_e12_led", {4'd0, pin_led}, 8'd0);
        run_to(14);
        check("wr_e14_pc", {4'd0, dut.pc}, 8'd3);
        run_to(16);
        check("wr_e16_a", {4'd0, dut.reg_a}, 8'd1);
        check("wr_e16_carry", {7'd0, dut.carry}, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
